// File: rtl/button_gesture_fsm_if.sv
// rtl/button_gesture_fsm_if.sv - button level in, gesture event pulses out
interface button_gesture_fsm_if;
  logic debounced_in;
  logic press_pulse;
  logic release_pulse;
  logic click;
  logic double_click;
  logic long_press;
  logic repeat_pulse;

  modport master (
    output debounced_in,
    input  press_pulse, release_pulse, click, double_click, long_press, repeat_pulse
  );

  modport slave (
    input  debounced_in,
    output press_pulse, release_pulse, click, double_click, long_press, repeat_pulse
  );
endinterface

// File: rtl/button_gesture_fsm.sv
// rtl/button_gesture_fsm.sv - classifies a debounced button level into registered gesture pulses
// Auto-repeat while long-held is built only when BUTTON_GESTURE_REPEAT_EN is defined.
module button_gesture_fsm #(
  parameter int LONG_TICKS   = 1000,
  parameter int GAP_TICKS    = 300,
  parameter int REPEAT_TICKS = 200
) (
  input logic                  clk,
  input logic                  rst,
  button_gesture_fsm_if.slave  bus
);

  localparam int MAX_LG = (LONG_TICKS > GAP_TICKS) ? LONG_TICKS : GAP_TICKS;
`ifdef BUTTON_GESTURE_REPEAT_EN
  localparam int MAX_T  = (MAX_LG > REPEAT_TICKS) ? MAX_LG : REPEAT_TICKS;
`else
  localparam int MAX_T  = MAX_LG;
`endif
  localparam int CW = $clog2(MAX_T) + 1;

  localparam logic [CW-1:0] LONG_LIM = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] GAP_LIM  = CW'(GAP_TICKS - 1);
`ifdef BUTTON_GESTURE_REPEAT_EN
  localparam logic [CW-1:0] REP_LIM  = CW'(REPEAT_TICKS - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESSED   = 3'd1,
    S_WAIT_GAP  = 3'd2,
    S_SECOND    = 3'd3,
    S_LONG_HELD = 3'd4
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] counter;
  logic          counter_run;
  logic          press_d, release_d, click_d, double_d, long_d, repeat_d;
  logic          in;

  assign in = bus.debounced_in;

  // State, counter and the registered event outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      counter            <= '0;
      bus.press_pulse    <= 1'b0;
      bus.release_pulse  <= 1'b0;
      bus.click          <= 1'b0;
      bus.double_click   <= 1'b0;
      bus.long_press     <= 1'b0;
      bus.repeat_pulse   <= 1'b0;
    end else begin
      state              <= state_next;
      if (state_next != state || repeat_d)
        counter <= '0;
      else if (counter_run)
        counter <= counter + 1'b1;
      bus.press_pulse    <= press_d;
      bus.release_pulse  <= release_d;
      bus.click          <= click_d;
      bus.double_click   <= double_d;
      bus.long_press     <= long_d;
      bus.repeat_pulse   <= repeat_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (in) state_next = S_PRESSED;
      S_PRESSED:   if (!in) state_next = S_WAIT_GAP;
                   else if (counter == LONG_LIM) state_next = S_LONG_HELD;
      S_WAIT_GAP:  if (in) state_next = S_SECOND;
                   else if (counter == GAP_LIM) state_next = S_IDLE;
      S_SECOND:    if (!in) state_next = S_IDLE;
                   else if (counter == LONG_LIM) state_next = S_LONG_HELD;
      S_LONG_HELD: if (!in) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Release is tested before the counter limit, so a release on the limit edge wins.
  always_comb begin
    press_d     = 1'b0;
    release_d   = 1'b0;
    click_d     = 1'b0;
    double_d    = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;
    counter_run = 1'b0;
    case (state)
      S_PRESSED: begin
        counter_run = 1'b1;
        if (!in) release_d = 1'b1;
        else if (counter == LONG_LIM) long_d = 1'b1;
      end
      S_WAIT_GAP: begin
        counter_run = 1'b1;
        if (in) press_d = 1'b1;
        else if (counter == GAP_LIM) click_d = 1'b1;
      end
      S_SECOND: begin
        counter_run = 1'b1;
        if (!in) begin
          release_d = 1'b1;
          double_d  = 1'b1;
        end else if (counter == LONG_LIM) begin
          long_d = 1'b1;
        end
      end
      S_LONG_HELD: begin
        if (!in) release_d = 1'b1;
`ifdef BUTTON_GESTURE_REPEAT_EN
        else begin
          counter_run = 1'b1;
          if (counter == REP_LIM) repeat_d = 1'b1;
        end
`endif
      end
      default: begin
        if (in) press_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_button_gesture_fsm.sv
// tb/tb_button_gesture_fsm.sv - directed-vector bench for button_gesture_fsm
module tb_button_gesture_fsm;

  localparam logic [5:0] E_PR = 6'b000001;
  localparam logic [5:0] E_RL = 6'b000010;
  localparam logic [5:0] E_CK = 6'b000100;
  localparam logic [5:0] E_DC = 6'b001000;
  localparam logic [5:0] E_LP = 6'b010000;
  localparam logic [5:0] E_RP = 6'b100000;
`ifdef BUTTON_GESTURE_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [5:0] obs[$];

  button_gesture_fsm_if bus ();

  button_gesture_fsm #(
    .LONG_TICKS   (8),
    .GAP_TICKS    (4),
    .REPEAT_TICKS (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One clock edge with the given rst/in, then capture the outputs 1 time unit later.
  task automatic drive(input logic r, input logic v);
    rst = r;
    bus.debounced_in = v;
    @(posedge clk);
    #1;
    obs.push_back({bus.repeat_pulse, bus.long_press, bus.double_click,
                   bus.click, bus.release_pulse, bus.press_pulse});
  endtask

  task automatic test_reset;
    logic [5:0] exp;
    obs.delete();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0);
    for (int i = 0; i < obs.size(); i++) begin
      exp = 6'b0;
      n_vec++;
      if (obs[i] !== exp) begin
        n_bad++;
        $display("FAIL reset cyc %0d: got %b want %b", i, obs[i], exp);
      end
    end
  endtask

  task automatic test_click;
    logic [5:0] exp;
    obs.delete();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0);
    for (int i = 0; i < obs.size(); i++) begin
      case (i)
        0:       exp = E_PR;
        3:       exp = E_RL;
        7:       exp = E_CK;
        default: exp = 6'b0;
      endcase
      n_vec++;
      if (obs[i] !== exp) begin
        n_bad++;
        $display("FAIL click cyc %0d: got %b want %b", i, obs[i], exp);
      end
    end
  endtask

  task automatic test_double_click;
    logic [5:0] exp;
    obs.delete();
    drive(1'b0, 1'b1); drive(1'b0, 1'b1);
    drive(1'b0, 1'b0); drive(1'b0, 1'b0);
    drive(1'b0, 1'b1); drive(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0);
    for (int i = 0; i < obs.size(); i++) begin
      case (i)
        0, 4:    exp = E_PR;
        2:       exp = E_RL;
        6:       exp = E_RL | E_DC;
        default: exp = 6'b0;
      endcase
      n_vec++;
      if (obs[i] !== exp) begin
        n_bad++;
        $display("FAIL double_click cyc %0d: got %b want %b", i, obs[i], exp);
      end
    end
  endtask

  task automatic test_long_repeat;
    logic [5:0] exp;
    obs.delete();
    for (int i = 0; i < 21; i++) drive(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0);
    for (int i = 0; i < obs.size(); i++) begin
      case (i)
        0:              exp = E_PR;
        8:              exp = E_LP;
        11, 14, 17, 20: exp = REP_EN ? E_RP : 6'b0;
        21:             exp = E_RL;
        default:        exp = 6'b0;
      endcase
      n_vec++;
      if (obs[i] !== exp) begin
        n_bad++;
        $display("FAIL long_repeat cyc %0d: got %b want %b", i, obs[i], exp);
      end
    end
  endtask

  task automatic test_release_wins;
    logic [5:0] exp;
    obs.delete();
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0);
    for (int i = 0; i < obs.size(); i++) begin
      case (i)
        0:       exp = E_PR;
        8:       exp = E_RL;
        12:      exp = E_CK;
        default: exp = 6'b0;
      endcase
      n_vec++;
      if (obs[i] !== exp) begin
        n_bad++;
        $display("FAIL release_wins cyc %0d: got %b want %b", i, obs[i], exp);
      end
    end
  endtask

  task automatic test_reset_abort;
    logic [5:0] exp;
    obs.delete();
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1); drive(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0);
    for (int i = 0; i < obs.size(); i++) begin
      case (i)
        0, 6:    exp = E_PR;
        8:       exp = E_RL;
        12:      exp = E_CK;
        default: exp = 6'b0;
      endcase
      n_vec++;
      if (obs[i] !== exp) begin
        n_bad++;
        $display("FAIL reset_abort cyc %0d: got %b want %b", i, obs[i], exp);
      end
    end
  endtask

  task automatic test_second_long;
    logic [5:0] exp;
    obs.delete();
    drive(1'b0, 1'b1); drive(1'b0, 1'b1);
    drive(1'b0, 1'b0); drive(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0);
    for (int i = 0; i < obs.size(); i++) begin
      case (i)
        0, 4:    exp = E_PR;
        2, 14:   exp = E_RL;
        12:      exp = E_LP;
        default: exp = 6'b0;
      endcase
      n_vec++;
      if (obs[i] !== exp) begin
        n_bad++;
        $display("FAIL second_long cyc %0d: got %b want %b", i, obs[i], exp);
      end
    end
  endtask

  initial begin
    bus.debounced_in = 1'b0;
    test_reset;
    test_click;
    test_double_click;
    test_long_repeat;
    test_release_wins;
    test_reset_abort;
    test_second_long;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
